// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// One multiplier bit (shift-add) or one quotient bit (restoring divide) is
// resolved per cycle on operand magnitudes; signs are reapplied in FIX.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       MdCtrl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 sign_a, sign_b, op_div, op_signed;
  logic [2*WIDTH-1:0]   acc;

  logic                 start_ok, accept_arith, accept_move;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0]   acc_step, prod_fix;
  logic [WIDTH-1:0]     quot_fix, rem_fix;
  logic                 flip;

  // Magnitude of a value, treated as two's complement only when sgn is set.
  // The most negative value maps to its own bit pattern, which is its correct
  // unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    logic signed [WIDTH-1:0] s;
    s = v;
    return (sgn && s < 0) ? WIDTH'(-s) : v;
  endfunction

  // Conditional two's complement negation, single word.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  // Conditional two's complement negation, double word.
  function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  // Flush blocks acceptance of any request in IDLE.
  assign start_ok     = (state == IDLE) && Start && !Flush;
  assign accept_arith = start_ok && !MdCtrl[2];
  assign accept_move  = start_ok && (MdCtrl[2:1] == 2'b10);

  // One iteration step. Multiply: acc = {partial high, remaining multiplier},
  // shifted right. Divide: acc = {remainder, dividend/quotient}, shifted left.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    if (op_div) begin
      acc_step = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Sign correction; a zero divisor forces an all-ones quotient while the
  // remainder already equals the dividend once its sign is restored.
  always_comb begin
    flip     = op_signed && (sign_a ^ sign_b);
    prod_fix = neg_d(acc, flip);
    quot_fix = (b_mag == '0) ? '1 : neg_w(acc[WIDTH-1:0], flip);
    rem_fix  = neg_w(acc[2*WIDTH-1:WIDTH], op_signed && sign_a);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: CALC runs exactly WIDTH cycles, Flush aborts to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_arith) state_nxt = CALC;
      CALC:    if (Flush) state_nxt = IDLE;
               else if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latches, accumulator, HI/LO and the Busy/Done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      a_mag     <= '0;
      b_mag     <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      acc       <= '0;
      HI        <= '0;
      LO        <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Busy <= (state_nxt != IDLE);
      Done <= 1'b0;
      if (accept_arith) begin
        a_mag     <= mag(SrcA, !MdCtrl[0]);
        b_mag     <= mag(SrcB, !MdCtrl[0]);
        sign_a    <= SrcA[WIDTH-1];
        sign_b    <= SrcB[WIDTH-1];
        op_div    <= MdCtrl[1];
        op_signed <= !MdCtrl[0];
        cnt       <= '0;
        acc       <= {{WIDTH{1'b0}}, MdCtrl[1] ? mag(SrcA, !MdCtrl[0]) : mag(SrcB, !MdCtrl[0])};
      end else if (accept_move) begin
        if (MdCtrl[0]) LO <= SrcA;
        else           HI <= SrcA;
        Done <= 1'b1;
      end else if (state == CALC && !Flush) begin
        acc <= acc_step;
        cnt <= cnt + CNT_W'(1);
      end else if (state == FIX && !Flush) begin
        if (op_div) begin
          HI <= rem_fix;
          LO <= quot_fix;
        end else begin
          HI <= prod_fix[2*WIDTH-1:WIDTH];
          LO <= prod_fix[WIDTH-1:0];
        end
        Done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, hand-written
// corner sequences, and randomized ops against an arithmetic reference model.
module tb_mul_div_unit;

  logic        clk, rst_n, Start, Flush;
  logic [2:0]  MdCtrl;
  logic [31:0] SrcA, SrcB;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_bad = 0;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .MdCtrl(MdCtrl),
    .SrcA(SrcA), .SrcB(SrcB), .Flush(Flush),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operand values.
  function automatic void model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    hi = 32'h0;
    lo = 32'h0;
    case (c)
      3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin p = 64'(ua * ub); hi = p[63:32]; lo = p[31:0]; end
      3'd2: begin
        if (b == 32'h0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin q = 64'(sa / sb); r = 64'(sa % sb); hi = r[31:0]; lo = q[31:0]; end
      end
      default: begin
        if (b == 32'h0) begin hi = a; lo = 32'hFFFFFFFF; end
        else begin q = ua / ub; r = ua % ub; hi = r[31:0]; lo = q[31:0]; end
      end
    endcase
  endfunction

  // Drive a request for one cycle; returns #1 after the accepting edge.
  task automatic start_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1; MdCtrl = c; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    Start = 1'b0;
  endtask

  // Count edges until Done, bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    while (Done !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    if (edges >= 100) check("done_timeout", {31'h0, Done}, 32'h1);
  endtask

  task automatic do_move(input logic [2:0] c, input logic [31:0] a);
    start_op(c, a, 32'h0);
    check("move_done", {31'h0, Done}, 32'h1);
    check("move_busy", {31'h0, Busy}, 32'h0);
  endtask

  vec_t vecs[10];
  logic [31:0] ehi, elo, hold_hi, hold_lo;
  int edges, seen;

  initial begin
    vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4] = '{3'd3, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
    vecs[5] = '{3'd2, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF};
    vecs[6] = '{3'd0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
    vecs[7] = '{3'd3, 32'd7,        32'hFFFFFFFF, 32'd7,        32'h00000000};
    vecs[8] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

    rst_n = 1'b0; Start = 1'b0; Flush = 1'b0; MdCtrl = 3'd0; SrcA = '0; SrcB = '0;
    #12;
    check("rst_busy", {31'h0, Busy}, 32'h0);
    check("rst_done", {31'h0, Done}, 32'h0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy", i), {31'h0, Busy}, 32'h1);
      wait_done(edges);
      check($sformatf("v%0d_lat", i), 32'(edges), 32'd33);
      check($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      check($sformatf("v%0d_lo", i), LO, vecs[i].lo);
      check($sformatf("v%0d_idle", i), {31'h0, Busy}, 32'h0);
      @(posedge clk); #1;
      check($sformatf("v%0d_pulse", i), {31'h0, Done}, 32'h0);
    end

    // Start with mthi while a divide is in flight is ignored.
    start_op(3'd3, 32'd100, 32'd0);
    repeat (5) @(negedge clk);
    Start = 1'b1; MdCtrl = 3'd4; SrcA = 32'hDEADBEEF;
    @(negedge clk); Start = 1'b0;
    check("busy_ignore_hi_mid", HI, 32'h40000000);
    wait_done(edges);
    check("busy_ignore_hi", HI, 32'd100);
    check("busy_ignore_lo", LO, 32'hFFFFFFFF);

    // Flush at cycle 10 of CALC.
    do_move(3'd4, 32'h11111111);
    do_move(3'd5, 32'h22222222);
    check("mthi_val", HI, 32'h11111111);
    check("mtlo_val", LO, 32'h22222222);
    start_op(3'd0, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1 Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    check("flush_busy", {31'h0, Busy}, 32'h0);
    check("flush_done", {31'h0, Done}, 32'h0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (Done) seen++; end
    check("flush_no_done", 32'(seen), 32'h0);
    check("flush_hi", HI, 32'h11111111);
    check("flush_lo", LO, 32'h22222222);

    // Flush in FIX suppresses the write.
    start_op(3'd1, 32'd9, 32'd9);
    repeat (32) @(posedge clk);
    #1 Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    check("fixflush_done", {31'h0, Done}, 32'h0);
    check("fixflush_busy", {31'h0, Busy}, 32'h0);
    check("fixflush_lo", LO, 32'h22222222);

    // Flush together with Start in IDLE: nothing accepted.
    @(negedge clk);
    Start = 1'b1; Flush = 1'b1; MdCtrl = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
    @(posedge clk); #1;
    check("fs_busy", {31'h0, Busy}, 32'h0);
    @(negedge clk); MdCtrl = 3'd4; SrcA = 32'hCAFEF00D;
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0;
    check("fs_done", {31'h0, Done}, 32'h0);
    check("fs_hi", HI, 32'h11111111);

    // mtlo then a mult started in the Done cycle.
    do_move(3'd5, 32'h12345678);
    check("mtlo_b2b", LO, 32'h12345678);
    Start = 1'b1; MdCtrl = 3'd0; SrcA = 32'd3; SrcB = 32'd4;
    @(posedge clk); #1;
    Start = 1'b0;
    check("b2b_busy", {31'h0, Busy}, 32'h1);
    wait_done(edges);
    check("b2b_lat", 32'(edges), 32'd33);
    check("b2b_lo", LO, 32'd12);
    check("b2b_hi", HI, 32'd0);

    // Asynchronous reset in the middle of CALC.
    start_op(3'd1, 32'hFFFF0000, 32'h0000FFFF);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("amid_busy", {31'h0, Busy}, 32'h0);
    check("amid_hi", HI, 32'h0);
    check("amid_lo", LO, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("arel_busy", {31'h0, Busy}, 32'h0);
    start_op(3'd1, 32'hFFFF0000, 32'h0000FFFF);
    wait_done(edges);
    model(3'd1, 32'hFFFF0000, 32'h0000FFFF, ehi, elo);
    check("arel_lat", 32'(edges), 32'd33);
    check("arel_hi", HI, ehi);
    check("arel_lo", LO, elo);

    // Random ops, issued back-to-back in each Done cycle.
    for (int i = 0; i < 1200; i++) begin
      logic [2:0]  c;
      logic [31:0] a, b;
      c = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'($urandom_range(0, 15));
        2: a = 32'h80000000;
        3: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        4: a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      model(c, a, b, ehi, elo);
      start_op(c, a, b);
      wait_done(edges);
      check($sformatf("r%0d_lat", i), 32'(edges), 32'd33);
      check($sformatf("r%0d_hi op%0d %h %h", i, c, a, b), HI, ehi);
      check($sformatf("r%0d_lo op%0d %h %h", i, c, a, b), LO, elo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
